// File: rtl/fpinga_pkg.sv
// Shared types and constants for the spectral-change operand generator.
package fpinga_pkg;

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned NUM_BINS_DEF   = 1024;

  // A difference held one bit wider than its operands has overflowed the
  // operand range exactly when its two top bits disagree.
  function automatic logic diff_overflows(input logic [1:0] top_bits);
    return top_bits[1] ^ top_bits[0];
  endfunction

endpackage

// File: rtl/fft_change_prep_frame_buffer.sv
// Previous-frame store: single-port read-first RAM with a registered read port.
module frame_buffer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_BINS   = 1024,
  localparam int unsigned AW        = $clog2(NUM_BINS)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [NUM_BINS];

  always_ff @(posedge clk) begin
    rdata <= mem[addr];
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/fft_change_prep.sv
// Per-bin operand generator: emits (current - previous, previous) for the
// divider, with saturation, divide-by-zero guard and frame framing checks.
module fft_change_prep
  import fpinga_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned NUM_BINS   = NUM_BINS_DEF
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          s_tvalid,
  input  logic [DATA_WIDTH-1:0]         s_tdata,
  input  logic                          s_tlast,
  output logic                          s_tready,
  output logic                          m_axis_divisor_tvalid,
  output logic [DATA_WIDTH-1:0]         m_axis_divisor_tdata,
  output logic [DATA_WIDTH-1:0]         m_axis_dividend_tdata,
  output logic [$clog2(NUM_BINS)-1:0]   m_bin,
  output logic                          m_tlast,
  output logic                          m_zero_div,
  output logic                          frame_err
);

  localparam int unsigned BW = $clog2(NUM_BINS);

  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t          state_q, state_d;
  logic [BW-1:0]   cnt_q, cnt_d;
  logic            accept;
  logic            at_top;
  logic            eof;
  logic            malformed;

  assign s_tready  = ~rst_in;
  assign accept    = s_tvalid & s_tready;
  assign at_top    = (cnt_q == BW'(NUM_BINS - 1));
  assign eof       = accept & (s_tlast | at_top);
  // Exactly one of the two end-of-frame causes means the frame length was wrong.
  assign malformed = accept & (s_tlast ^ at_top);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (accept) begin
      cnt_d = eof ? '0 : cnt_q + BW'(1);
      if (eof && state_q == PRIME) begin
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= PRIME;
      cnt_q     <= '0;
      frame_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      frame_err <= malformed;
    end
  end

  // Stage 1: the RAM read and these side-band registers land on the same edge.
  logic [DATA_WIDTH-1:0] prev_rd;
  logic                  s1_valid;
  logic [DATA_WIDTH-1:0] s1_cur;
  logic [BW-1:0]         s1_bin;
  logic                  s1_last;

  frame_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_BINS   (NUM_BINS)
  ) u_frame_buffer (
    .clk   (clk_in),
    .we    (accept),
    .addr  (cnt_q),
    .wdata (s_tdata),
    .rdata (prev_rd)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s1_cur   <= '0;
      s1_bin   <= '0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= accept & (state_q == RUN);
      s1_cur   <= s_tdata;
      s1_bin   <= cnt_q;
      s1_last  <= eof;
    end
  end

  // Stage 2: subtract, saturate, zero guard.
  logic [DATA_WIDTH:0]   diff;
  logic [DATA_WIDTH-1:0] dividend_d;
  logic [DATA_WIDTH-1:0] divisor_d;
  logic                  zero_d;

  always_comb begin
    diff = {s1_cur[DATA_WIDTH-1], s1_cur} - {prev_rd[DATA_WIDTH-1], prev_rd};
    dividend_d = diff[DATA_WIDTH-1:0];
    if (diff_overflows(diff[DATA_WIDTH:DATA_WIDTH-1])) begin
      dividend_d = diff[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    zero_d    = (prev_rd == '0);
    divisor_d = zero_d ? DATA_WIDTH'(1) : prev_rd;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      m_axis_divisor_tvalid <= 1'b0;
      m_axis_divisor_tdata  <= '0;
      m_axis_dividend_tdata <= '0;
      m_bin                 <= '0;
      m_tlast               <= 1'b0;
      m_zero_div            <= 1'b0;
    end else begin
      m_axis_divisor_tvalid <= s1_valid;
      if (s1_valid) begin
        m_axis_divisor_tdata  <= divisor_d;
        m_axis_dividend_tdata <= dividend_d;
        m_bin                 <= s1_bin;
        m_tlast               <= s1_last;
        m_zero_div            <= zero_d;
      end
    end
  end

endmodule

// File: tb/tb_fft_change_prep.sv
// Directed self-checking bench for fft_change_prep with a 16-bin frame.
module tb_fft_change_prep;

  localparam int N = 16;
  localparam int W = 32;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          s_tvalid;
  logic [W-1:0]  s_tdata;
  logic          s_tlast;
  logic          s_tready;
  logic          m_axis_divisor_tvalid;
  logic [W-1:0]  m_axis_divisor_tdata;
  logic [W-1:0]  m_axis_dividend_tdata;
  logic [3:0]    m_bin;
  logic          m_tlast;
  logic          m_zero_div;
  logic          frame_err;

  fft_change_prep #(
    .DATA_WIDTH (W),
    .NUM_BINS   (N)
  ) dut (
    .clk_in                (clk_in),
    .rst_in                (rst_in),
    .s_tvalid              (s_tvalid),
    .s_tdata               (s_tdata),
    .s_tlast               (s_tlast),
    .s_tready              (s_tready),
    .m_axis_divisor_tvalid (m_axis_divisor_tvalid),
    .m_axis_divisor_tdata  (m_axis_divisor_tdata),
    .m_axis_dividend_tdata (m_axis_dividend_tdata),
    .m_bin                 (m_bin),
    .m_tlast               (m_tlast),
    .m_zero_div            (m_zero_div),
    .frame_err             (frame_err)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [3:0]  bin;
    logic        tl;
    logic        zd;
  } rec_t;

  rec_t out_q[$];
  int   err_q[$];

  always @(negedge clk_in) begin
    if (m_axis_divisor_tvalid)
      out_q.push_back('{cyc, m_axis_dividend_tdata, m_axis_divisor_tdata, m_bin, m_tlast, m_zero_div});
    if (frame_err)
      err_q.push_back(cyc);
  end

  int          total = 0;
  int          bad   = 0;
  longint      prev_m[N];
  logic [31:0] cur[N];
  int          in_cyc[N];
  rec_t        got[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sat_diff(input longint c, input longint p);
    longint d;
    d = c - p;
    if (d > 64'sd2147483647) d = 64'sd2147483647;
    if (d < -64'sd2147483648) d = -64'sd2147483648;
    return d[31:0];
  endfunction

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_bin(input logic [31:0] v, input logic last, output int t);
    t        = cyc;
    s_tvalid = 1'b1;
    s_tdata  = v;
    s_tlast  = last;
    tick();
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < N; i++) cur[i] = v;
  endtask

  task automatic run_frame(input int n, input logic tl, input int gap, input logic prime);
    logic        malformed;
    longint      c, p;
    for (int i = 0; i < n; i++) begin
      drive_bin(cur[i], tl && (i == n - 1), in_cyc[i]);
      repeat (gap) tick();
    end
    repeat (4) tick();
    check("out_count", out_q.size(), prime ? 0 : n);
    if (!prime && out_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        got[i] = out_q.pop_front();
        c = $signed(cur[i]);
        p = prev_m[i];
        check("bin", got[i].bin, i);
        check("dividend", got[i].dvd, sat_diff(c, p));
        check("divisor", got[i].dvs, (p == 0) ? 32'd1 : p[31:0]);
        check("zero_div", got[i].zd, p == 0);
        check("tlast", got[i].tl, i == n - 1);
        check("latency", got[i].cyc, in_cyc[i] + 2);
      end
    end
    malformed = tl ? (n < N) : (n == N);
    check("err_count", err_q.size(), malformed);
    if (malformed && err_q.size() == 1)
      check("err_cycle", err_q[0], in_cyc[n-1] + 1);
    for (int i = 0; i < n; i++) prev_m[i] = $signed(cur[i]);
    out_q.delete();
    err_q.delete();
  endtask

  task automatic do_reset();
    rst_in   = 1'b1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tick();
    tick();
    check("rst_tready", s_tready, 1'b0);
    check("rst_valid", m_axis_divisor_tvalid, 1'b0);
    rst_in = 1'b0;
    tick();
    out_q.delete();
    err_q.delete();
  endtask

  initial begin
    rst_in   = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    repeat (3) tick();
    check("reset_tready", s_tready, 1'b0);
    check("reset_valid", m_axis_divisor_tvalid, 1'b0);
    check("reset_divisor", m_axis_divisor_tdata, 32'd0);
    check("reset_dividend", m_axis_dividend_tdata, 32'd0);
    check("reset_bin", m_bin, 4'd0);
    check("reset_tlast", m_tlast, 1'b0);
    check("reset_zero_div", m_zero_div, 1'b0);
    check("reset_frame_err", frame_err, 1'b0);
    rst_in = 1'b0;
    tick();
    check("ready_after_reset", s_tready, 1'b1);
    out_q.delete();
    err_q.delete();

    // Prime then steady frame
    fill(32'd9);
    run_frame(N, 1'b1, 0, 1'b1);
    fill(32'd255);
    run_frame(N, 1'b1, 0, 1'b0);
    check("steady_dvd", got[0].dvd, 32'd246);
    check("steady_dvs", got[0].dvs, 32'd9);
    check("steady_last_bin", got[15].bin, 4'd15);
    check("steady_last_tl", got[15].tl, 1'b1);

    // Zero guard
    do_reset();
    fill(32'd0);
    run_frame(N, 1'b1, 0, 1'b1);
    fill(32'd1111);
    run_frame(N, 1'b1, 0, 1'b0);
    check("zero_dvs", got[4].dvs, 32'd1);
    check("zero_dvd", got[4].dvd, 32'd1111);
    check("zero_flag", got[4].zd, 1'b1);

    // Saturation both ways
    fill(32'd5);
    cur[0] = 32'h8000_0000;
    cur[1] = 32'h7FFF_FFFF;
    run_frame(N, 1'b1, 0, 1'b0);
    check("sat_neg_from_1111", got[0].dvd, 32'h8000_0000);
    check("nosat_pos", got[1].dvd, 32'h7FFF_FBA8);
    cur[0] = 32'h7FFF_FFFF;
    cur[1] = 32'h8000_0000;
    run_frame(N, 1'b1, 0, 1'b0);
    check("sat_max", got[0].dvd, 32'h7FFF_FFFF);
    check("sat_min", got[1].dvd, 32'h8000_0000);
    check("neg_divisor", got[0].dvs, 32'h8000_0000);

    // Short frame, then a full frame sees old values on bins 6..15
    fill(32'd100);
    run_frame(6, 1'b1, 0, 1'b0);
    fill(32'd7);
    run_frame(N, 1'b1, 0, 1'b0);
    check("short_next_bin0", got[0].bin, 4'd0);
    check("short_new_dvs", got[2].dvs, 32'd100);
    check("short_old_dvs6", got[6].dvs, 32'd5);
    check("short_old_dvs15", got[15].dvs, 32'd5);

    // Missing tlast: forced m_tlast and counter wrap
    fill(32'd8);
    run_frame(N, 1'b0, 0, 1'b0);
    check("forced_tlast", got[15].tl, 1'b1);
    fill(32'd9);
    run_frame(N, 1'b1, 0, 1'b0);
    check("wrap_bin0", got[0].bin, 4'd0);
    check("wrap_dvd", got[0].dvd, 32'd1);

    // Bubbles
    for (int i = 0; i < N; i++) cur[i] = 32'(i * 1000);
    run_frame(N, 1'b1, 1, 1'b0);
    check("bubble_spacing", got[1].cyc - got[0].cyc, 32'd2);
    check("bubble_dvd3", got[3].dvd, 32'd2991);

    // Reset mid-frame
    fill(32'd30);
    for (int i = 0; i < 7; i++) drive_bin(cur[i], 1'b0, in_cyc[i]);
    rst_in   = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 32'd30;
    tick();
    check("midrst_valid", m_axis_divisor_tvalid, 1'b0);
    check("midrst_tready", s_tready, 1'b0);
    s_tvalid = 1'b0;
    tick();
    rst_in = 1'b0;
    tick();
    out_q.delete();
    err_q.delete();
    fill(32'd50);
    run_frame(N, 1'b1, 0, 1'b1);
    fill(32'd60);
    run_frame(N, 1'b1, 0, 1'b0);
    check("post_rst_dvd", got[0].dvd, 32'd10);
    check("post_rst_dvs", got[9].dvs, 32'd50);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
